// File: rtl/twos_to_signmag_pkg.sv
// rtl/twos_to_signmag_pkg.sv - shared FSM states and default operand width
package twos_to_signmag_pkg;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  localparam int default_width = 16;

endpackage

// File: rtl/twos_to_signmag_serial_negate_bit.sv
// rtl/twos_to_signmag_serial_negate_bit.sv - one-bit serial negate cell
// Copies bits up to and including the first 1, inverts every later bit when sign is set.
module serial_negate_bit (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  input  logic sign,
  input  logic bit_in,
  output logic bit_out
);

  logic seen_one;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seen_one <= 1'b0;
    end else if (clear) begin
      seen_one <= 1'b0;
    end else if (enable) begin
      seen_one <= seen_one | bit_in;
    end
  end

  assign bit_out = bit_in ^ (sign & seen_one);

endmodule

// File: rtl/twos_to_signmag.sv
// rtl/twos_to_signmag.sv - bit-serial two's-complement to sign/magnitude converter
// One bit per cycle, LSB first; result is held in DONE until the consumer takes it.
module twos_to_signmag
  import twos_to_signmag_pkg::*;
#(
  parameter int WIDTH = default_width
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_sign,
  output logic [WIDTH-1:0] out_mag,
  output logic             out_ovf
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0]    last_bit = CW'(WIDTH - 1);
  localparam logic [WIDTH-1:0] most_neg = {1'b1, {(WIDTH-1){1'b0}}};

  state_t           state, state_nxt;
  logic [WIDTH-1:0] sreg;
  logic [CW-1:0]    cnt;
  logic             accept;
  logic             shift_en;
  logic             bit_out;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    accept    = 1'b0;
    shift_en  = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          accept    = 1'b1;
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        shift_en = 1'b1;
        if (cnt == last_bit) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // The only operand whose magnitude needs all WIDTH bits is the most negative one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sreg     <= '0;
      cnt      <= '0;
      out_sign <= 1'b0;
      out_mag  <= '0;
      out_ovf  <= 1'b0;
    end else if (accept) begin
      sreg     <= in_data;
      cnt      <= '0;
      out_sign <= in_data[WIDTH-1];
      out_mag  <= '0;
      out_ovf  <= (in_data == most_neg);
    end else if (shift_en) begin
      sreg    <= sreg >> 1;
      out_mag <= {bit_out, out_mag[WIDTH-1:1]};
      cnt     <= (cnt == last_bit) ? '0 : cnt + 1'b1;
    end
  end

  serial_negate_bit u_negate (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (accept),
    .enable  (shift_en),
    .sign    (out_sign),
    .bit_in  (sreg[0]),
    .bit_out (bit_out)
  );

endmodule

// File: tb/tb_twos_to_signmag.sv
// tb/tb_twos_to_signmag.sv - scoreboard bench for twos_to_signmag
module tb_twos_to_signmag;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic         out_sign;
  logic [W-1:0] out_mag;
  logic         out_ovf;

  twos_to_signmag #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sign  (out_sign),
    .out_mag   (out_mag),
    .out_ovf   (out_ovf)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_total = 0;
  int n_pass  = 0;

  logic [W+1:0] sb_q[$];
  int           lat_q[$];
  logic         prev_valid = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  // Monitor: latency on out_valid rise, result comparison on each transfer.
  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid && !prev_valid) begin
        if (lat_q.size() == 0) check("latency_unexpected", 1, 0);
        else check("latency", cyc - lat_q.pop_front(), W);
      end
      if (out_valid && out_ready) begin
        if (sb_q.size() == 0) begin
          check("unexpected_output", 1, 0);
        end else begin
          logic [W+1:0] e;
          e = sb_q.pop_front();
          check("out_sign", out_sign, e[W+1]);
          check("out_mag", out_mag, e[W:1]);
          check("out_ovf", out_ovf, e[0]);
        end
      end
    end
    prev_valid = out_valid;
  end

  // Drives one operand in the posedge+1 phase; returns cycles spent waiting for in_ready.
  task automatic send(input logic [W-1:0] d, input logic es, input logic [W-1:0] em,
                      input logic eo, input bit expect_out, output int waited);
    waited = 0;
    while (!in_ready && waited < 100) begin
      @(posedge clk); #1;
      waited++;
    end
    if (!in_ready) check("in_ready_timeout", 0, 1);
    in_valid = 1'b1;
    in_data  = d;
    @(posedge clk); #1;
    lat_q.push_back(cyc);
    if (expect_out) sb_q.push_back({es, em, eo});
    in_valid = 1'b0;
    in_data  = $urandom;
  endtask

  initial begin
    int w;
    int k;
    logic [W-1:0] x;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_sign", out_sign, 0);
    check("rst_out_mag", out_mag, 0);
    check("rst_out_ovf", out_ovf, 0);
    rst_n = 1'b1;

    send(16'h0005, 1'b0, 16'h0005, 1'b0, 1'b1, w);
    check("first_edge_accept", w, 0);
    send(16'hFFFB, 1'b1, 16'h0005, 1'b0, 1'b1, w);
    send(16'h8001, 1'b1, 16'h7FFF, 1'b0, 1'b1, w);
    send(16'h8000, 1'b1, 16'h8000, 1'b1, 1'b1, w);
    send(16'h0000, 1'b0, 16'h0000, 1'b0, 1'b1, w);
    send(16'h7FFF, 1'b0, 16'h7FFF, 1'b0, 1'b1, w);
    send(16'hFFFF, 1'b1, 16'h0001, 1'b0, 1'b1, w);

    // Back-pressure: result must hold for 5 stalled cycles.
    @(posedge clk); #1;
    while (in_ready == 1'b0) begin @(posedge clk); #1; end
    out_ready = 1'b0;
    send(16'hFFFB, 1'b1, 16'h0005, 1'b0, 1'b1, w);
    k = 0;
    while (!out_valid && k < 40) begin @(posedge clk); #1; k++; end
    check("stall_valid_seen", out_valid, 1);
    for (int i = 0; i < 5; i++) begin
      check("stall_valid", out_valid, 1);
      check("stall_in_ready", in_ready, 0);
      check("stall_sign", out_sign, 1);
      check("stall_mag", out_mag, 16'h0005);
      check("stall_ovf", out_ovf, 0);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("release_valid", out_valid, 0);
    check("release_in_ready", in_ready, 1);

    // Reset mid-SHIFT at bit 8 of 0xFFFB.
    send(16'hFFFB, 1'b1, 16'h0005, 1'b0, 1'b0, w);
    repeat (8) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    lat_q.delete();
    check("abort_out_valid", out_valid, 0);
    check("abort_in_ready", in_ready, 1);
    check("abort_out_mag", out_mag, 0);
    repeat (3) begin
      @(posedge clk); #1;
      check("abort_hold_valid", out_valid, 0);
    end
    rst_n = 1'b1;
    repeat (20) begin
      @(posedge clk); #1;
      check("after_abort_valid", out_valid, 0);
    end
    send(16'h0003, 1'b0, 16'h0003, 1'b0, 1'b1, w);
    check("post_reset_accept", w, 0);

    // Round trip: negated positive values come back as sign=1, magnitude x.
    for (int i = 0; i < 1000; i++) begin
      x = W'($urandom_range(1, 32767));
      send(~x + 16'd1, 1'b1, x, 1'b0, 1'b1, w);
    end

    k = 0;
    while (sb_q.size() != 0 && k < 100) begin @(posedge clk); #1; k++; end
    check("drain_empty", sb_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
